// File: rtl/sprite_fetch_sched.sv
// Per-pixel SRAM read scheduler: walks hit sprites top-down then background, first non-key pixel wins.
// Latency: winner j -> pix_valid in cycle j+2; no backpressure, a start during FETCH is dropped and flagged in overrun.
module sprite_fetch_sched #(
    parameter int              N_SPR = 2,
    parameter int              AW    = 17,
    parameter int              DW    = 12,
    parameter logic [DW-1:0]   KEY   = 'h0F0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [AW-1:0]       bg_addr,
    input  logic [N_SPR-1:0]    spr_hit,
    input  logic [N_SPR*AW-1:0] spr_addr,
    output logic                sram_en,
    output logic [AW-1:0]       sram_addr,
    input  logic [DW-1:0]       sram_dout,
    output logic [DW-1:0]       pix_out,
    output logic                pix_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int NC = N_SPR + 1;
    localparam int IW = $clog2(NC);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    state_t          state, state_d;
    logic [AW-1:0]   cand_d [NC];
    logic [AW-1:0]   cand_q [NC];
    logic [IW-1:0]   n_hit;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   rd_idx;
    logic [IW-1:0]   nxt_idx;
    logic [AW-1:0]   addr_hold;
    logic            accept;
    logic            win;

    // Compact hit sprites, topmost first; background fills every slot after them.
    always_comb begin
        for (int j = 0; j < NC; j++) begin
            cand_d[j] = bg_addr;
        end
        n_hit = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (spr_hit[i]) begin
                cand_d[n_hit] = spr_addr[i*AW +: AW];
                n_hit         = n_hit + IW'(1);
            end
        end
    end

    assign accept    = start && reset_n && (state != S_FETCH);
    assign nxt_idx   = rd_idx + IW'(1);
    assign win       = (rd_idx == last_q) || (sram_dout != KEY);
    assign pix_valid = (state == S_DONE);
    assign busy      = (state == S_FETCH);

    always_comb begin
        state_d   = state;
        sram_en   = 1'b0;
        sram_addr = addr_hold;
        case (state)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d   = S_FETCH;
                    sram_en   = 1'b1;
                    sram_addr = cand_d[0];
                end
            end
            S_FETCH: begin
                if (win) begin
                    state_d = S_DONE;
                end else begin
                    sram_en   = 1'b1;
                    sram_addr = cand_q[nxt_idx];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pix_out   <= '0;
            overrun   <= 1'b0;
            rd_idx    <= '0;
            last_q    <= '0;
            addr_hold <= '0;
            for (int j = 0; j < NC; j++) begin
                cand_q[j] <= '0;
            end
        end else begin
            state     <= state_d;
            addr_hold <= sram_addr;
            if (accept) begin
                cand_q <= cand_d;
                last_q <= n_hit;
                rd_idx <= '0;
            end
            if (state == S_FETCH) begin
                if (start) begin
                    overrun <= 1'b1;
                end
                if (win) begin
                    pix_out <= sram_dout;
                end else begin
                    rd_idx <= nxt_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Bench for sprite_fetch_sched: vector table through a scoreboard plus overrun and mid-slot reset sequences.
module tb_sprite_fetch_sched;

    localparam int N_SPR = 2;
    localparam int AW    = 17;
    localparam int DW    = 12;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                start;
    logic [AW-1:0]       bg_addr;
    logic [N_SPR-1:0]    spr_hit;
    logic [N_SPR*AW-1:0] spr_addr;
    logic                sram_en;
    logic [AW-1:0]       sram_addr;
    logic [DW-1:0]       sram_dout;
    logic [DW-1:0]       pix_out;
    logic                pix_valid;
    logic                busy;
    logic                overrun;

    always #5 clk = ~clk;

    sprite_fetch_sched #(.N_SPR(N_SPR), .AW(AW), .DW(DW), .KEY(12'h0F0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bg_addr   (bg_addr),
        .spr_hit   (spr_hit),
        .spr_addr  (spr_addr),
        .sram_en   (sram_en),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Single-port SRAM: data appears the cycle after the address cycle.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_en) sram_dout <= mem[sram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    hit;
        logic [AW-1:0] bg, a0, a1;
        logic [DW-1:0] dbg, d0, d1, pix;
        int            lat;
        int            nrd;
        logic [AW-1:0] first, last;
    } vec_t;

    typedef struct {
        logic [DW-1:0] pix;
        int            st;
        int            lat;
        int            nrd;
        logic [AW-1:0] first, last;
    } exp_t;

    exp_t sb[$];
    vec_t vt[9];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endfunction

    // Monitor: count reads per slot, compare each result against the scoreboard head.
    int            rd_cnt = 0;
    logic [AW-1:0] rd_first, rd_last;
    exp_t          e;
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_cnt = 0;
        end else begin
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_pix_valid", 32'(pix_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("pix_out", 32'(pix_out), 32'(e.pix));
                    chk("latency", cyc - e.st, e.lat);
                    chk("read_count", rd_cnt, e.nrd);
                    chk("first_addr", 32'(rd_first), 32'(e.first));
                    chk("last_addr", 32'(rd_last), 32'(e.last));
                end
                rd_cnt = 0;
            end
            if (sram_en) begin
                if (rd_cnt == 0) rd_first = sram_addr;
                rd_last = sram_addr;
                rd_cnt++;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input vec_t v);
        mem[v.bg] = v.dbg;
        mem[v.a0] = v.d0;
        mem[v.a1] = v.d1;
    endtask

    task automatic apply(input vec_t v);
        spr_hit  = v.hit;
        bg_addr  = v.bg;
        spr_addr = {v.a1, v.a0};
        start    = 1'b1;
    endtask

    task automatic push_exp(input logic [DW-1:0] pix, input int lat, input int nrd,
                            input logic [AW-1:0] first, input logic [AW-1:0] last);
        exp_t x;
        x.pix = pix; x.st = cyc; x.lat = lat; x.nrd = nrd; x.first = first; x.last = last;
        sb.push_back(x);
    endtask

    // Change every input after cycle 0 so a design that re-reads them gets caught.
    task automatic scramble;
        start    = 1'b0;
        spr_hit  = '1;
        bg_addr  = '1;
        spr_addr = '1;
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        chk(nm, 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int pv;
        vt[0] = '{2'b00, 17'h10, 17'h200, 17'h100, 12'hABC, 12'h111, 12'h222, 12'hABC, 2, 1, 17'h10,  17'h10};
        vt[1] = '{2'b11, 17'h11, 17'h201, 17'h101, 12'h777, 12'h456, 12'h123, 12'h123, 2, 1, 17'h101, 17'h101};
        vt[2] = '{2'b11, 17'h12, 17'h202, 17'h102, 12'h777, 12'h456, 12'h0F0, 12'h456, 3, 2, 17'h102, 17'h202};
        vt[3] = '{2'b11, 17'h13, 17'h203, 17'h103, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 4, 3, 17'h103, 17'h13};
        vt[4] = '{2'b01, 17'h14, 17'h204, 17'h104, 12'h5A5, 12'h0F0, 12'h999, 12'h5A5, 3, 2, 17'h204, 17'h14};
        vt[5] = '{2'b10, 17'h15, 17'h205, 17'h105, 12'h888, 12'h0F0, 12'h321, 12'h321, 2, 1, 17'h105, 17'h105};
        vt[6] = '{2'b00, 17'h16, 17'h206, 17'h106, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 2, 1, 17'h16,  17'h16};
        vt[7] = '{2'b10, 17'h17, 17'h207, 17'h107, 12'h0F1, 12'h0F0, 12'h0F0, 12'h0F1, 3, 2, 17'h107, 17'h17};
        vt[8] = '{2'b01, 17'h18, 17'h208, 17'h108, 12'h0F0, 12'h00F, 12'h0F0, 12'h00F, 2, 1, 17'h208, 17'h208};
        for (int i = 0; i < 9; i++) load(vt[i]);
        mem[17'h1FFFF] = 12'h555;

        reset_n  = 1'b0;
        start    = 1'b0;
        spr_hit  = '0;
        bg_addr  = '0;
        spr_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pix_out", 32'(pix_out), 32'(0));
        chk("reset_pix_valid", 32'(pix_valid), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_overrun", 32'(overrun), 32'(0));
        chk("reset_sram_en", 32'(sram_en), 32'(0));
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step();
            apply(vt[i]);
            push_exp(vt[i].pix, vt[i].lat, vt[i].nrd, vt[i].first, vt[i].last);
            step();
            scramble();
            drain($sformatf("drain_vec%0d", i));
        end

        // Start during FETCH is dropped; start in the DONE cycle is taken at once.
        step();
        apply(vt[3]);
        push_exp(vt[3].pix, vt[3].lat, vt[3].nrd, vt[3].first, vt[3].last);
        step();
        scramble();
        step();
        spr_hit = 2'b00; bg_addr = 17'h10; start = 1'b1;
        step();
        scramble();
        @(negedge clk);
        chk("overrun_set", 32'(overrun), 32'(1));
        chk("busy_cycle3", 32'(busy), 32'(1));
        step();
        spr_hit = 2'b00; bg_addr = 17'h10; spr_addr = '0; start = 1'b1;
        push_exp(12'hABC, 2, 1, 17'h10, 17'h10);
        @(negedge clk);
        chk("done_pix_valid", 32'(pix_valid), 32'(1));
        chk("done_start_sram_en", 32'(sram_en), 32'(1));
        chk("done_start_sram_addr", 32'(sram_addr), 32'(17'h10));
        step();
        scramble();
        drain("drain_overrun_seq");
        chk("overrun_sticky", 32'(overrun), 32'(1));

        // Reset in cycle 1 of a two-read slot abandons it.
        step();
        apply(vt[2]);
        step();
        scramble();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_sram_en", 32'(sram_en), 32'(0));
        chk("rst_mid_pix_out", 32'(pix_out), 32'(0));
        chk("rst_mid_overrun", 32'(overrun), 32'(0));
        chk("rst_mid_pix_valid", 32'(pix_valid), 32'(0));
        pv = 0;
        repeat (5) begin
            @(negedge clk);
            if (pix_valid) pv++;
        end
        chk("rst_mid_no_result", pv, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
